// File: rtl/if_fetch_unit_if.sv
// Wishbone classic read-only bus between the fetch unit (master) and instruction memory (slave).
interface if_fetch_unit_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    cyc;
  logic                    stb;
  logic                    we;
  logic [DATA_WIDTH/8-1:0] sel;
  logic [ADDR_WIDTH-1:0]   adr;
  logic [DATA_WIDTH-1:0]   dat;
  logic                    ack;

  modport master (output cyc, stb, we, sel, adr, input dat, ack);
  modport slave  (input cyc, stb, we, sel, adr, output dat, ack);
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: Wishbone classic fetch, registered IF/ID outputs, stall and redirect.
// Optional IF_FETCH_CNT_EN adds fetch_cnt_o, a count of delivered instructions.
module if_fetch_unit #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] PC_ADDR    = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall_i,
  input  logic                  redirect_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  if_fetch_unit_if.master       wb,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic                  instr_valid_o
`ifdef IF_FETCH_CNT_EN
  , output logic [31:0]         fetch_cnt_o
`endif
);

  localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] pc_q, adr_q, pc_out_q, hold_pc_q;
  logic [DATA_WIDTH-1:0] instr_q, hold_dat_q;
  logic                  cyc_q, valid_q, redirect_pend_q;

  logic [ADDR_WIDTH-1:0] redirect_tgt_d, pc_inc_d, deliver_pc_d;
  logic [DATA_WIDTH-1:0] deliver_dat_d;
  logic                  deliver_d;

  always_comb begin
    redirect_tgt_d = redirect_pc_i & ~ADDR_WIDTH'(3);
    pc_inc_d       = pc_q + ADDR_WIDTH'(4);
    // A word reaches IF/ID either straight off the bus or out of the hold buffer.
    deliver_d      = !redirect_i && !stall_i &&
                     ((state_q == FETCH && wb.ack && !redirect_pend_q) || state_q == HOLD);
    deliver_dat_d  = (state_q == HOLD) ? hold_dat_q : wb.dat;
    deliver_pc_d   = (state_q == HOLD) ? hold_pc_q : pc_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      pc_q            <= PC_ADDR;
      adr_q           <= '0;
      cyc_q           <= 1'b0;
      redirect_pend_q <= 1'b0;
      hold_dat_q      <= '0;
      hold_pc_q       <= '0;
      instr_q         <= NOP;
      pc_out_q        <= '0;
      valid_q         <= 1'b0;
    end else begin
      if (redirect_i) begin
        valid_q <= 1'b0;
        instr_q <= NOP;
      end else if (deliver_d) begin
        instr_q  <= deliver_dat_d;
        pc_out_q <= deliver_pc_d;
        valid_q  <= 1'b1;
      end else if (!stall_i) begin
        valid_q <= 1'b0;
        instr_q <= NOP;
      end

      if (redirect_i)     pc_q <= redirect_tgt_d;
      else if (deliver_d) pc_q <= pc_inc_d;

      case (state_q)
        IDLE: begin
          if (!redirect_i) begin
            cyc_q   <= 1'b1;
            adr_q   <= pc_q;
            state_q <= FETCH;
          end
        end
        FETCH: begin
          if (wb.ack) begin
            cyc_q           <= 1'b0;
            redirect_pend_q <= 1'b0;
            hold_dat_q      <= wb.dat;
            hold_pc_q       <= pc_q;
            state_q         <= (!redirect_i && !redirect_pend_q && stall_i) ? HOLD : IDLE;
          end else if (redirect_i) begin
            // Classic Wishbone cannot abort; let the cycle finish and drop its data.
            redirect_pend_q <= 1'b1;
          end
        end
        HOLD: begin
          if (redirect_i || !stall_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef IF_FETCH_CNT_EN
  logic [31:0] fetch_cnt_q;
  always_ff @(posedge clk) begin
    if (reset)          fetch_cnt_q <= '0;
    else if (deliver_d) fetch_cnt_q <= fetch_cnt_q + 32'd1;
  end
  assign fetch_cnt_o = fetch_cnt_q;
`endif

  assign wb.cyc        = cyc_q;
  assign wb.stb        = cyc_q;
  assign wb.we         = 1'b0;
  assign wb.sel        = '1;
  assign wb.adr        = adr_q;
  assign instr_o       = instr_q;
  assign pc_o          = pc_out_q;
  assign instr_valid_o = valid_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios plus a randomized run against a transaction-level model.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] PC0 = 32'h8000_0000;

  logic        clk, reset, stall_i, redirect_i;
  logic [31:0] redirect_pc_i, instr_o, pc_o;
  logic        instr_valid_o;
`ifdef IF_FETCH_CNT_EN
  logic [31:0] fetch_cnt_o;
`endif

  if_fetch_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  if_fetch_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .PC_ADDR(32'h8000_0000)) dut (
    .clk           (clk),
    .reset         (reset),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .wb            (bus),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .instr_valid_o (instr_valid_o)
`ifdef IF_FETCH_CNT_EN
    , .fetch_cnt_o (fetch_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // memory slave state
  int   ws_next   = 0;
  int   wait_left = 0;
  logic force_ack = 1'b0;

  // reference model: what IF/ID should show and where the next fetch must go
  logic [31:0] m_pc, e_instr, e_pc, held_d, held_pc, e_cnt;
  logic        e_valid, held_v, discard;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0010_0093;
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
  endfunction

  function automatic void m_deliver(input logic [31:0] d, input logic [31:0] p);
    e_instr = d; e_pc = p; e_valid = 1'b1;
    m_pc = m_pc + 32'd4; e_cnt = e_cnt + 32'd1; held_v = 1'b0;
  endfunction

  // Drive one cycle of inputs plus the memory response, advance the model, sample #1 after the edge.
  task automatic tick(input logic s, input logic r, input logic [31:0] rpc);
    logic        a;
    logic [31:0] d;
    stall_i = s; redirect_i = r; redirect_pc_i = rpc;
    a = 1'b0; d = 32'hDEAD_BEEF;
    if (force_ack) begin
      a = 1'b1; wait_left = ws_next;
    end else if (bus.cyc && bus.stb) begin
      if (wait_left == 0) begin a = 1'b1; d = mem_word(bus.adr); end
      else wait_left = wait_left - 1;
    end else begin
      wait_left = ws_next;
    end
    bus.ack = a; bus.dat = d;
    if (reset) begin
      m_pc = PC0; held_v = 1'b0; discard = 1'b0;
      e_instr = NOP; e_pc = 32'h0; e_valid = 1'b0; e_cnt = 32'h0;
    end else if (r) begin
      m_pc = rpc & ~32'd3; held_v = 1'b0; discard = bus.cyc && !a;
      e_valid = 1'b0; e_instr = NOP;
    end else if (a && bus.cyc) begin
      if (discard) begin
        discard = 1'b0;
        if (!s) begin e_valid = 1'b0; e_instr = NOP; end
      end else if (!s) m_deliver(d, m_pc);
      else begin held_v = 1'b1; held_d = d; held_pc = m_pc; end
    end else if (held_v && !s) begin
      m_deliver(held_d, held_pc);
    end else if (!s) begin
      e_valid = 1'b0; e_instr = NOP;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 32'h0);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    ws_next = 0;
    do_reset();
    n_checks++;
    if ({bus.cyc, bus.stb, bus.we, bus.sel, bus.adr} !== {3'b000, 4'hF, 32'h0})
      $display("FAIL reset_bus: cyc/stb/we/sel/adr=%b%b%b %h %h want 000 f 00000000",
               bus.cyc, bus.stb, bus.we, bus.sel, bus.adr);
    else n_pass++;
    n_checks++;
    if ({instr_o, pc_o, instr_valid_o} !== {NOP, 32'h0, 1'b0})
      $display("FAIL reset_ifid: instr=%h pc=%h v=%b want %h 00000000 0", instr_o, pc_o, instr_valid_o, NOP);
    else n_pass++;
  endtask

  task automatic test_first_fetch();
    ws_next = 0;
    do_reset();
    tick(1'b0, 1'b0, 32'h0);
    n_checks++;
    if ({bus.cyc, bus.stb, bus.adr} !== {2'b11, PC0})
      $display("FAIL first_adr: cyc=%b stb=%b adr=%h want 1 1 %h", bus.cyc, bus.stb, bus.adr, PC0);
    else n_pass++;
    tick(1'b0, 1'b0, 32'h0);
    n_checks++;
    if ({instr_o, pc_o, instr_valid_o} !== {32'h0010_0093, PC0, 1'b1})
      $display("FAIL first_instr: instr=%h pc=%h v=%b want 00100093 %h 1", instr_o, pc_o, instr_valid_o, PC0);
    else n_pass++;
    tick(1'b0, 1'b0, 32'h0);
    n_checks++;
    if ({bus.cyc, bus.adr, instr_valid_o, instr_o} !== {1'b1, 32'h8000_0004, 1'b0, NOP})
      $display("FAIL second_adr: cyc=%b adr=%h v=%b instr=%h want 1 80000004 0 %h",
               bus.cyc, bus.adr, instr_valid_o, instr_o, NOP);
    else n_pass++;
  endtask

  task automatic test_wait_states();
    ws_next = 3;
    do_reset();
    tick(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, 32'h0);
      n_checks++;
      if ({bus.cyc, bus.stb, bus.adr, instr_valid_o, instr_o} !== {2'b11, PC0, 1'b0, NOP})
        $display("FAIL wait_hold[%0d]: cyc=%b stb=%b adr=%h v=%b instr=%h want 1 1 %h 0 %h",
                 i, bus.cyc, bus.stb, bus.adr, instr_valid_o, instr_o, PC0, NOP);
      else n_pass++;
    end
    tick(1'b0, 1'b0, 32'h0);
    n_checks++;
    if ({instr_o, pc_o, instr_valid_o, bus.cyc} !== {32'h0010_0093, PC0, 2'b10})
      $display("FAIL wait_deliver: instr=%h pc=%h v=%b cyc=%b want 00100093 %h 1 0",
               instr_o, pc_o, instr_valid_o, bus.cyc, PC0);
    else n_pass++;
  endtask

  task automatic test_stall_hold();
    ws_next = 0;
    do_reset();
    tick(1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, 1'b0, 32'h0);
      n_checks++;
      if ({instr_o, pc_o, instr_valid_o} !== {32'h0010_0093, PC0, 1'b1})
        $display("FAIL stall_frozen[%0d]: instr=%h pc=%h v=%b want 00100093 %h 1", i, instr_o, pc_o, instr_valid_o, PC0);
      else n_pass++;
      if (i >= 1) begin
        n_checks++;
        if (bus.cyc !== 1'b0) $display("FAIL hold_bus_idle[%0d]: cyc=%b want 0", i, bus.cyc);
        else n_pass++;
      end
    end
    tick(1'b0, 1'b0, 32'h0);
    n_checks++;
    if ({instr_o, pc_o, instr_valid_o} !== {mem_word(32'h8000_0004), 32'h8000_0004, 1'b1})
      $display("FAIL hold_release: instr=%h pc=%h v=%b want %h 80000004 1",
               instr_o, pc_o, instr_valid_o, mem_word(32'h8000_0004));
    else n_pass++;
  endtask

  task automatic test_redirect_mid();
    ws_next = 2;
    do_reset();
    tick(1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b1, 32'h8000_0102);
    tick(1'b0, 1'b0, 32'h0);
    n_checks++;
    if ({bus.cyc, bus.adr, instr_valid_o} !== {1'b1, PC0, 1'b0})
      $display("FAIL redir_bus_kept: cyc=%b adr=%h v=%b want 1 %h 0", bus.cyc, bus.adr, instr_valid_o, PC0);
    else n_pass++;
    tick(1'b0, 1'b0, 32'h0);
    n_checks++;
    if ({bus.cyc, instr_valid_o, instr_o} !== {2'b00, NOP})
      $display("FAIL redir_discard: cyc=%b v=%b instr=%h want 0 0 %h", bus.cyc, instr_valid_o, instr_o, NOP);
    else n_pass++;
    ws_next = 0;
    tick(1'b0, 1'b0, 32'h0);
    n_checks++;
    if ({bus.cyc, bus.adr} !== {1'b1, 32'h8000_0100})
      $display("FAIL redir_target: cyc=%b adr=%h want 1 80000100", bus.cyc, bus.adr);
    else n_pass++;
    tick(1'b0, 1'b0, 32'h0);
    n_checks++;
    if ({instr_o, pc_o, instr_valid_o} !== {mem_word(32'h8000_0100), 32'h8000_0100, 1'b1})
      $display("FAIL redir_deliver: instr=%h pc=%h v=%b want %h 80000100 1",
               instr_o, pc_o, instr_valid_o, mem_word(32'h8000_0100));
    else n_pass++;
  endtask

  task automatic test_redirect_ack_stall();
    ws_next = 0;
    do_reset();
    tick(1'b0, 1'b0, 32'h0);
    tick(1'b1, 1'b1, 32'h1234_5677);
    n_checks++;
    if ({bus.cyc, instr_valid_o, instr_o} !== {2'b00, NOP})
      $display("FAIL redir_ack_drop: cyc=%b v=%b instr=%h want 0 0 %h", bus.cyc, instr_valid_o, instr_o, NOP);
    else n_pass++;
    tick(1'b1, 1'b0, 32'h0);
    n_checks++;
    if ({bus.cyc, bus.adr} !== {1'b1, 32'h1234_5674})
      $display("FAIL redir_ack_nohold: cyc=%b adr=%h want 1 12345674", bus.cyc, bus.adr);
    else n_pass++;
    tick(1'b0, 1'b0, 32'h0);
    n_checks++;
    if ({instr_o, pc_o, instr_valid_o} !== {mem_word(32'h1234_5674), 32'h1234_5674, 1'b1})
      $display("FAIL redir_ack_next: instr=%h pc=%h v=%b want %h 12345674 1",
               instr_o, pc_o, instr_valid_o, mem_word(32'h1234_5674));
    else n_pass++;
  endtask

  task automatic test_pc_wrap();
    ws_next = 0;
    do_reset();
    tick(1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b1, 32'hFFFF_FFFE);
    tick(1'b0, 1'b0, 32'h0);
    n_checks++;
    if (bus.adr !== 32'hFFFF_FFFC) $display("FAIL wrap_target: adr=%h want fffffffc", bus.adr);
    else n_pass++;
    tick(1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 32'h0);
    n_checks++;
    if ({bus.cyc, bus.adr, pc_o} !== {1'b1, 32'h0, 32'hFFFF_FFFC})
      $display("FAIL wrap_zero: cyc=%b adr=%h pc=%h want 1 00000000 fffffffc", bus.cyc, bus.adr, pc_o);
    else n_pass++;
  endtask

  task automatic test_count_and_reset();
    ws_next = 0;
    do_reset();
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b1, PC0);
`ifdef IF_FETCH_CNT_EN
    n_checks++;
    if (fetch_cnt_o !== 32'd5) $display("FAIL cnt_five: cnt=%0d want 5", fetch_cnt_o);
    else n_pass++;
`endif
    ws_next = 3;
    tick(1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 32'h0);
    reset = 1'b1;
    tick(1'b0, 1'b0, 32'h0);
    reset = 1'b0;
    n_checks++;
    if ({bus.cyc, instr_valid_o} !== 2'b00)
      $display("FAIL reset_midfetch: cyc=%b v=%b want 0 0", bus.cyc, instr_valid_o);
    else n_pass++;
`ifdef IF_FETCH_CNT_EN
    n_checks++;
    if (fetch_cnt_o !== 32'd0) $display("FAIL cnt_reset: cnt=%0d want 0", fetch_cnt_o);
    else n_pass++;
`endif
    ws_next = 0;
    force_ack = 1'b1;
    tick(1'b0, 1'b0, 32'h0);
    force_ack = 1'b0;
    n_checks++;
    if ({bus.cyc, bus.adr, instr_valid_o} !== {1'b1, PC0, 1'b0})
      $display("FAIL late_ack_ignored: cyc=%b adr=%h v=%b want 1 %h 0", bus.cyc, bus.adr, instr_valid_o, PC0);
    else n_pass++;
    tick(1'b0, 1'b0, 32'h0);
    n_checks++;
    if ({instr_o, pc_o, instr_valid_o} !== {32'h0010_0093, PC0, 1'b1})
      $display("FAIL restart_deliver: instr=%h pc=%h v=%b want 00100093 %h 1", instr_o, pc_o, instr_valid_o, PC0);
    else n_pass++;
  endtask

  task automatic test_random();
    logic        pcyc;
    logic [31:0] padr;
    ws_next = 0;
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      pcyc = bus.cyc; padr = bus.adr;
      ws_next = $urandom_range(0, 3);
      tick(($urandom_range(0, 9) < 3), ($urandom_range(0, 19) == 0), $urandom);
      n_checks++;
      if ({instr_o, pc_o, instr_valid_o} !== {e_instr, e_pc, e_valid})
        $display("FAIL rnd_ifid[%0d]: instr=%h pc=%h v=%b want %h %h %b",
                 i, instr_o, pc_o, instr_valid_o, e_instr, e_pc, e_valid);
      else n_pass++;
      if (bus.cyc && !pcyc) begin
        n_checks++;
        if (bus.adr !== m_pc) $display("FAIL rnd_fetch_adr[%0d]: adr=%h want %h", i, bus.adr, m_pc);
        else n_pass++;
      end else if (bus.cyc && pcyc) begin
        n_checks++;
        if (bus.adr !== padr) $display("FAIL rnd_adr_stable[%0d]: adr=%h want %h", i, bus.adr, padr);
        else n_pass++;
      end
      if (held_v) begin
        n_checks++;
        if (bus.cyc !== 1'b0) $display("FAIL rnd_hold_idle[%0d]: cyc=%b want 0", i, bus.cyc);
        else n_pass++;
      end
`ifdef IF_FETCH_CNT_EN
      n_checks++;
      if (fetch_cnt_o !== e_cnt) $display("FAIL rnd_cnt[%0d]: cnt=%0d want %0d", i, fetch_cnt_o, e_cnt);
      else n_pass++;
`endif
    end
  endtask

  initial begin
    reset = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
    bus.ack = 1'b0; bus.dat = 32'h0;
    test_reset();
    test_first_fetch();
    test_wait_states();
    test_stall_hold();
    test_redirect_mid();
    test_redirect_ack_stall();
    test_pc_wrap();
    test_count_and_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
